// File: rtl/tff_counter_ctrl.sv
// Sequencer driving an external T flip-flop bank through a count sequence.
// It computes per-bit toggles and checks the bank's q feedback.
module tff_counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             pause,
  input  logic             up,
  input  logic             wrap_en,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] t_out,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_dir;
  logic             r_wrap;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] r_exp;
  logic             r_tc;
  logic             r_err;

  logic [WIDTH-1:0] w_exp_nxt;
  logic [WIDTH-1:0] w_sv;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_t;
  logic             w_term;
  logic             w_cap;
  logic             w_tc_nxt;
  logic             w_chk;

  // Next state, next expected count and toggle vector.
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_t         = '0;
    w_cap       = 1'b0;
    w_tc_nxt    = 1'b0;
    w_sv        = r_dir ? '0 : r_limit;
    // Up never passes the limit since it starts at 0.
    w_term      = r_dir ? (r_exp >= r_limit)
                        : (r_exp == '0);
    if (r_dir) begin
      w_cnt_nxt = w_term ? '0 : r_exp + ONE;
    end else begin
      w_cnt_nxt = w_term ? r_limit : r_exp - ONE;
    end
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cap       = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_t         = q_in ^ w_sv;
        w_exp_nxt   = w_sv;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Pause wins over the terminal check.
        if (!pause) begin
          if (w_term && !r_wrap) begin
            w_state_nxt = S_DONE;
          end else begin
            w_t       = q_in ^ w_cnt_nxt;
            w_exp_nxt = w_cnt_nxt;
            w_tc_nxt  = w_term;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          w_cap       = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_chk = (r_state == S_RUN) ||
                 (r_state == S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Sequence settings, captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_dir   <= 1'b0;
      r_wrap  <= 1'b0;
      r_limit <= '0;
    end else if (w_cap) begin
      r_dir   <= up;
      r_wrap  <= wrap_en;
      r_limit <= limit;
    end
  end

  // Expected bank value and wrap pulse.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_exp <= '0;
      r_tc  <= 1'b0;
    end else begin
      r_exp <= w_exp_nxt;
      r_tc  <= w_tc_nxt;
    end
  end

  // Sticky feedback error.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_err <= 1'b0;
    end else if (w_chk && (q_in != r_exp)) begin
      r_err <= 1'b1;
    end
  end

  assign t_out = clear ? '0 : w_t;
  assign busy  = (r_state == S_LOAD) ||
                 (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign tc    = r_tc;
  assign err   = r_err;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Bench for tff_counter_ctrl with a behavioural T-FF bank.
// Expected per-cycle outputs are queued and checked on the falling edge.
module tb_tff_counter_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clear;
  logic         start;
  logic         pause;
  logic         up;
  logic         wrap_en;
  logic [W-1:0] limit;
  logic [W-1:0] q_in;
  logic [W-1:0] t_out;
  logic         busy;
  logic         done;
  logic         tc;
  logic         err;

  logic [W-1:0] bq;
  logic [W-1:0] inj;

  typedef struct {
    int         tn;
    logic [3:0] q;
    logic [3:0] t;
    logic       b;
    logic       d;
    logic       c;
    logic       e;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   tn     = 0;

  always #5 clk = ~clk;

  tff_counter_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .clear   (clear),
    .start   (start),
    .pause   (pause),
    .up      (up),
    .wrap_en (wrap_en),
    .limit   (limit),
    .q_in    (q_in),
    .t_out   (t_out),
    .busy    (busy),
    .done    (done),
    .tc      (tc),
    .err     (err)
  );

  // T-FF bank; inj flips bits to emulate a pre-load or a fault.
  always @(posedge clk) begin
    if (clear) bq <= '0;
    else       bq <= bq ^ t_out ^ inj;
  end
  assign q_in = bq;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk($sformatf("t%0d.q", me.tn), 32'(bq), 32'(me.q));
      chk($sformatf("t%0d.t", me.tn), 32'(t_out), 32'(me.t));
      chk($sformatf("t%0d.busy", me.tn), 32'(busy), 32'(me.b));
      chk($sformatf("t%0d.done", me.tn), 32'(done), 32'(me.d));
      chk($sformatf("t%0d.tc", me.tn), 32'(tc), 32'(me.c));
      chk($sformatf("t%0d.err", me.tn), 32'(err), 32'(me.e));
    end
  end

  task automatic cyc(input logic st, input logic ps,
                     input logic cl, input logic [3:0] ij,
                     input logic [3:0] eq,
                     input logic [3:0] et,
                     input logic eb, input logic ed,
                     input logic ec, input logic ee);
    exp_t e;
    start = st;
    pause = ps;
    clear = cl;
    inj   = ij;
    e = '{tn, eq, et, eb, ed, ec, ee};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear   = 1'b1;
    start   = 1'b0;
    pause   = 1'b0;
    up      = 1'b0;
    wrap_en = 1'b0;
    limit   = '0;
    inj     = '0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    cyc(0,0,1,0, 0,0, 0,0,0,0);

    // 1: up one-shot to 5
    tn = 1; up = 1; wrap_en = 0; limit = 5;
    cyc(1,0,0,0, 0,0, 0,0,0,0);
    up = 0; limit = 2; wrap_en = 1;
    cyc(0,0,0,0, 0,0, 1,0,0,0);
    for (int k = 0; k <= 5; k++)
      cyc(0,0,0,0, 4'(k),
          (k < 5) ? 4'(k ^ (k+1)) : 4'h0,
          1,0,0,0);
    repeat (2) cyc(0,0,0,0, 5,0, 0,1,0,0);

    // 2: restart from DONE, up wrap limit 3
    tn = 2; up = 1; wrap_en = 1; limit = 3;
    cyc(1,0,0,0, 5,0, 0,1,0,0);
    cyc(0,0,0,0, 5,5, 1,0,0,0);
    for (int i = 0; i < 10; i++)
      cyc((i == 5), 0,0,0, 4'(i % 4),
          4'((i % 4) ^ ((i+1) % 4)),
          1,0, (i > 0 && i % 4 == 0), 0);
    cyc(0,0,1,0, 2,0, 1,0,0,0);

    // 3: down one-shot from 9, bank pre-set to 6
    tn = 3; up = 0; wrap_en = 0; limit = 9;
    cyc(0,0,0,6, 0,0, 0,0,0,0);
    cyc(1,0,0,0, 6,0, 0,0,0,0);
    cyc(0,0,0,0, 6,4'hF, 1,0,0,0);
    for (int v = 9; v >= 0; v--)
      cyc(0,0,0,0, 4'(v),
          (v > 0) ? 4'(v ^ (v-1)) : 4'h0,
          1,0,0,0);
    repeat (2) cyc(0,0,0,0, 0,0, 0,1,0,0);
    cyc(0,0,1,0, 0,0, 0,1,0,0);

    // 4: up wrap limit 15 with pause at 7
    tn = 4; up = 1; wrap_en = 1; limit = 15;
    cyc(1,0,0,0, 0,0, 0,0,0,0);
    cyc(0,0,0,0, 0,0, 1,0,0,0);
    for (int v = 0; v < 7; v++)
      cyc(0,0,0,0, 4'(v), 4'(v ^ (v+1)), 1,0,0,0);
    repeat (3) cyc(0,1,0,0, 7,0, 1,0,0,0);
    for (int v = 7; v <= 15; v++)
      cyc(0,0,0,0, 4'(v), 4'(v) ^ 4'(v+1),
          1,0,0,0);
    cyc(0,0,0,0, 0,1, 1,0,1,0);
    cyc(0,0,0,0, 1,3, 1,0,0,0);
    cyc(0,0,1,0, 2,0, 1,0,0,0);

    // 5: fault on bit 2 mid-RUN
    tn = 5; up = 1; wrap_en = 0; limit = 9;
    cyc(1,0,0,0, 0,0, 0,0,0,0);
    cyc(0,0,0,0, 0,0, 1,0,0,0);
    cyc(0,0,0,0, 0,1, 1,0,0,0);
    cyc(0,0,0,0, 1,3, 1,0,0,0);
    cyc(0,0,0,4, 2,1, 1,0,0,0);
    cyc(0,0,0,0, 7,3, 1,0,0,0);
    cyc(0,0,0,0, 4,1, 1,0,0,1);
    cyc(0,0,0,0, 5,3, 1,0,0,1);
    cyc(0,0,0,0, 6,1, 1,0,0,1);
    cyc(0,0,1,0, 7,0, 1,0,0,1);

    // 6: clear at q=4, start in RUN ignored
    tn = 6; up = 1; wrap_en = 0; limit = 6;
    cyc(1,0,0,0, 0,0, 0,0,0,0);
    up = 0; limit = 1;
    cyc(0,0,0,0, 0,0, 1,0,0,0);
    cyc(0,0,0,0, 0,1, 1,0,0,0);
    cyc(1,0,0,0, 1,3, 1,0,0,0);
    cyc(0,0,0,0, 2,1, 1,0,0,0);
    cyc(0,0,0,0, 3,7, 1,0,0,0);
    cyc(0,0,1,0, 4,0, 1,0,0,0);
    cyc(0,0,0,0, 0,0, 0,0,0,0);

    // 7: limit 0, one-shot then wrap
    tn = 7; up = 1; wrap_en = 0; limit = 0;
    cyc(1,0,0,0, 0,0, 0,0,0,0);
    cyc(0,0,0,0, 0,0, 1,0,0,0);
    cyc(0,0,0,0, 0,0, 1,0,0,0);
    wrap_en = 1;
    cyc(1,0,0,0, 0,0, 0,1,0,0);
    cyc(0,0,0,0, 0,0, 1,0,0,0);
    cyc(0,0,0,0, 0,0, 1,0,0,0);
    cyc(0,0,0,0, 0,0, 1,0,1,0);
    cyc(0,1,0,0, 0,0, 1,0,1,0);
    cyc(0,0,0,0, 0,0, 1,0,0,0);
    cyc(0,1,0,0, 0,0, 1,0,1,0);
    cyc(0,1,1,0, 0,0, 1,0,0,0);
    cyc(0,0,0,0, 0,0, 0,0,0,0);

    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
